// File: rtl/risc_bus_pkg.sv
// Shared types and constants for the RISC memory bus: access FSM states,
// default widths and the I/O window base address helper.
package risc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } bus_state_e;

   localparam int DEF_DW = 8;
   localparam int DEF_AW = 8;

   // First address of the I/O window; everything below it is RAM.
   function automatic longint io_base(input int aw, input int io_ports);
      return (longint'(1) << aw) - longint'(io_ports);
   endfunction

endpackage

// File: rtl/risc_sram.sv
// Single-port RAM array: synchronous write, registered read that holds its
// value until the next read enable.
module risc_sram #(
   parameter int DW    = 8,
   parameter int DEPTH = 252,
   localparam int ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic             re,
   input  logic [ABITS-1:0] addr,
   input  logic [DW-1:0]    wdata,
   output logic [DW-1:0]    rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/risc_mem_bus.sv
// Memory subsystem for the 8-bit RISC core: req/ready access FSM with
// programmable wait states, RAM below the I/O window and an I/O register bank.
module risc_mem_bus
   import risc_bus_pkg::*;
#(
   parameter int DW          = DEF_DW,
   parameter int AW          = DEF_AW,
   parameter int WAIT_STATES = 1,
   parameter int IO_PORTS    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [AW-1:0]          cpu_addr,
   input  logic [DW-1:0]          cpu_wdata,
   output logic [DW-1:0]          cpu_rdata,
   output logic                   cpu_ready,
   output logic                   bus_busy,
   input  logic [IO_PORTS*DW-1:0] io_in,
   output logic [IO_PORTS*DW-1:0] io_out,
   output bus_state_e             dbg_state
);

   // Handshake: cpu_req (with cpu_we/addr/wdata) is sampled only in IDLE;
   // once accepted the access always runs to completion and cpu_ready
   // pulses for exactly one cycle, with cpu_rdata valid in that cycle.

   localparam longint        IO_BASE_L = io_base(AW, IO_PORTS);
   localparam logic [AW-1:0] IO_BASE   = AW'(IO_BASE_L);
   localparam int            RAM_DEPTH = int'(IO_BASE_L);
   localparam int            RAW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int            PW        = (IO_PORTS > 1) ? $clog2(IO_PORTS) : 1;
   localparam logic [3:0]    WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   bus_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;

   logic [AW-1:0]    acc_addr;
   logic             acc_we;
   logic             acc_io;
   logic [PW-1:0]    acc_port;
   logic             rd_load;
   logic             wr_commit;
   logic [DW-1:0]    ram_rdata;
   logic [DW-1:0]    io_rd_q;
   logic             rd_io_q;
   logic [IO_PORTS*DW-1:0] io_out_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               state_d = (WAIT_STATES == 0) ? DONE : WAIT;
               cnt_d   = WAIT_INIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == IDLE && cpu_req) begin
         we_q    <= cpu_we;
         addr_q  <= cpu_addr;
         wdata_q <= cpu_wdata;
      end
   end

   // With zero wait states the read happens on the accepting edge itself,
   // so the live request fields are used while still in IDLE.
   assign acc_addr  = (state_q == IDLE) ? cpu_addr : addr_q;
   assign acc_we    = (state_q == IDLE) ? cpu_we   : we_q;
   assign acc_io    = (acc_addr >= IO_BASE);
   assign acc_port  = PW'(acc_addr - IO_BASE);
   assign rd_load   = (state_d == DONE) && (state_q != DONE) && !acc_we;
   assign wr_commit = (state_q == DONE) && we_q;

   risc_sram #(
      .DW    (DW),
      .DEPTH (RAM_DEPTH)
   ) u_sram (
      .clk   (clk),
      .rst_n (reset),
      .we    (wr_commit && !acc_io),
      .re    (rd_load && !acc_io),
      .addr  (RAW'(acc_addr)),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         io_rd_q  <= '0;
         rd_io_q  <= 1'b0;
         io_out_q <= '0;
      end else begin
         if (rd_load) rd_io_q <= acc_io;
         if (rd_load && acc_io) io_rd_q <= io_in[acc_port*DW +: DW];
         if (wr_commit && acc_io) io_out_q[acc_port*DW +: DW] <= wdata_q;
      end
   end

   // The last completed read's source selects which registered word is shown.
   assign cpu_rdata = rd_io_q ? io_rd_q : ram_rdata;
   assign cpu_ready = (state_q == DONE);
   assign bus_busy  = (state_q != IDLE);
   assign io_out    = io_out_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_risc_mem_bus.sv
// Bench for risc_mem_bus: a WAIT_STATES=2 instance and a WAIT_STATES=0
// instance driven by directed accesses, checked through expected-data queues.
module tb_risc_mem_bus;
   import risc_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        req = 1'b0, we = 1'b0;
   logic [7:0]  addr = '0, wdata = '0;
   logic [7:0]  rdata;
   logic        ready, busy;
   logic [31:0] io_in_v = '0;
   logic [31:0] io_out_v;
   bus_state_e  dbg;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [7:0]  addr0 = '0, wdata0 = '0;
   logic [7:0]  rdata0;
   logic        ready0, busy0;
   logic [31:0] io_in0 = '0;
   logic [31:0] io_out0;
   bus_state_e  dbg0;

   logic [7:0]  exp_q[$];
   logic [7:0]  exp0_q[$];
   logic [7:0]  e1, e0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   risc_mem_bus #(.DW(8), .AW(8), .WAIT_STATES(2), .IO_PORTS(4)) u_dut (
      .clk(clk), .reset(rst_n), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_ready(ready), .bus_busy(busy),
      .io_in(io_in_v), .io_out(io_out_v), .dbg_state(dbg)
   );

   risc_mem_bus #(.DW(8), .AW(8), .WAIT_STATES(0), .IO_PORTS(4)) u_dut0 (
      .clk(clk), .reset(rst_n), .cpu_req(req0), .cpu_we(we0), .cpu_addr(addr0),
      .cpu_wdata(wdata0), .cpu_rdata(rdata0), .cpu_ready(ready0), .bus_busy(busy0),
      .io_in(io_in0), .io_out(io_out0), .dbg_state(dbg0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: every ready pulse consumes one expected cpu_rdata value.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ready_unexpected: got ready=1 expected none at %0t", $time);
         end else begin
            e1 = exp_q.pop_front();
            chk("rdata_ws2", {24'd0, rdata}, {24'd0, e1});
         end
      end
   end

   always @(negedge clk) begin
      if (ready0 === 1'b1) begin
         if (exp0_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ready0_unexpected: got ready=1 expected none at %0t", $time);
         end else begin
            e0 = exp0_q.pop_front();
            chk("rdata_ws0", {24'd0, rdata0}, {24'd0, e0});
         end
      end
   end

   // One access with a single-cycle request; checks latency and busy span.
   task automatic access(input bit sel, input bit w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
      int lat, busy_n, ws;
      bit seen;
      ws = sel ? 0 : 2;
      @(posedge clk); #1;
      if (sel) begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; exp0_q.push_back(exp_rd);
      end else begin
         req = 1'b1; we = w; addr = a; wdata = d; exp_q.push_back(exp_rd);
      end
      @(posedge clk); #1;
      if (sel) begin
         req0 = 1'b0; we0 = ~w; addr0 = 8'($urandom_range(0, 255)); wdata0 = 8'($urandom_range(0, 255));
      end else begin
         req = 1'b0; we = ~w; addr = 8'($urandom_range(0, 255)); wdata = 8'($urandom_range(0, 255));
      end
      lat = 1; busy_n = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sel ? busy0 : busy) busy_n++;
         if (sel ? ready0 : ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      chk("ready_seen", {31'd0, seen}, 32'd1);
      chk("latency", lat, ws + 1);
      chk("busy_cycles", busy_n, ws + 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int t, prev, n;

      // Reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_io_out", io_out_v, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_ready0", {31'd0, ready0}, 32'd0);
      chk("rst_rdata0", {24'd0, rdata0}, 32'd0);

      // Pre-clear 0x20, then RAM round trip
      access(1'b0, 1'b1, 8'h20, 8'h00, 8'h00);
      access(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
      access(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);

      // I/O window
      access(1'b0, 1'b1, 8'hFD, 8'hC3, 8'h5A);
      chk("io_out_fd", io_out_v, 32'h0000_C300);
      io_in_v = 32'h1122_3344;
      access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h11);
      access(1'b0, 1'b0, 8'hFC, 8'h00, 8'h44);
      chk("io_out_hold", io_out_v, 32'h0000_C300);
      access(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);

      // Request held high: three back-to-back reads every 4 cycles
      @(posedge clk); #1;
      repeat (3) exp_q.push_back(8'h5A);
      req = 1'b1; we = 1'b0; addr = 8'h10;
      t = 0; prev = 0; n = 0;
      for (int i = 0; i < 60 && n < 3; i++) begin
         @(negedge clk);
         t++;
         if (ready) begin
            if (n > 0) chk("b2b_gap", t - prev, 4);
            prev = t;
            n++;
            if (n == 3) req = 1'b0;
         end
      end
      chk("b2b_count", n, 3);
      @(posedge clk); #1;

      // Reset in the middle of a write
      req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'hEE;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_io_out", io_out_v, 32'd0);
      chk("mid_rdata", {24'd0, rdata}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      access(1'b0, 1'b0, 8'h20, 8'h00, 8'h00);

      // Zero wait-state instance
      access(1'b1, 1'b1, 8'h30, 8'h30, 8'h00);
      access(1'b1, 1'b0, 8'h30, 8'h00, 8'h30);

      repeat (6) @(posedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("exp0_q_drained", exp0_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
